// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
// jk_bank_driver : computes minimal J/K excitation to move an external JK
//                  flop bank to a target word, then verifies the Q feedback.
// Rev 1.0
// ============================================================================
module jk_bank_driver #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             tgl_mode,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_drive  = 2'd1;
  localparam logic [1:0] c_st_settle = 2'd2;
  localparam logic [1:0] c_st_check  = 2'd3;
  localparam logic [7:0] c_settle    = 8'(SETTLE);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] r_err_mask;
  logic [7:0]       r_cnt;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_mismatch;

  // Mode only shapes the excitation captured at acceptance, so it needs no latch.
  always_comb begin
    w_j = '0;
    w_k = '0;
    if (tgl_mode) begin
      w_j = q_fb ^ tgt_data;
      w_k = q_fb ^ tgt_data;
    end else begin
      w_j = ~q_fb & tgt_data;
      w_k = q_fb & ~tgt_data;
    end
  end

  assign w_mismatch = q_fb ^ r_tgt;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state    <= c_st_idle;
      r_j        <= '0;
      r_k        <= '0;
      r_tgt      <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_mask <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == c_st_check);
      r_j     <= '0;
      r_k     <= '0;
      case (r_state)
        c_st_idle: begin
          if (tgt_valid) begin
            r_j   <= w_j;
            r_k   <= w_k;
            r_tgt <= tgt_data;
          end
        end
        c_st_drive:  r_cnt <= c_settle;
        c_st_settle: r_cnt <= r_cnt - 8'd1;
        c_st_check: begin
          r_err_mask <= w_mismatch;
          r_err      <= |w_mismatch;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:   if (tgt_valid) w_next = c_st_drive;
      c_st_drive:  w_next = c_st_settle;
      c_st_settle: if (r_cnt == 8'd1) w_next = c_st_check;
      c_st_check:  w_next = c_st_idle;
      default:     w_next = c_st_idle;
    endcase
  end

  always_comb begin
    tgt_ready = (r_state == c_st_idle);
    busy      = (r_state != c_st_idle);
    J         = r_j;
    K         = r_k;
    done      = r_done;
    err       = r_err;
    err_mask  = r_err_mask;
  end

endmodule
`default_nettype wire
